mdc_entradas: RTL and testbench

Input front-end for the coffee-machine state machine `maquina_de_cafe`. It synchronises and debounces the raw café/té buttons and measures the coin-sensor pulse to classify 5 and 10 coins. It produces the held level signals `hm`, `mc`, `md`, `bp`, `bc` and `bt` that the machine consumes. The outputs stay latched until the machine acknowledges with `clr`, or until a timeout abandons an incomplete transaction.

---
 rtl/mdc_pkg.sv | 22 ++
 rtl/mdc_antirrebote.sv | 48 ++++
 rtl/mdc_entradas.sv | 155 +++++++++++++++
 tb/tb_mdc_entradas.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mdc_pkg.sv
// Shared types and default constants for the coffee-machine input front-end.
package mdc_pkg;

    localparam int CNT_W          = 8;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int C5_MIN_DEF     = 4;
    localparam int C5_MAX_DEF     = 7;
    localparam int C10_MIN_DEF    = 10;
    localparam int C10_MAX_DEF    = 15;
    localparam int TIMEOUT_DEF    = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        CLAS = 2'd2
    } coin_st_e;

    function automatic logic in_range(input logic [CNT_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/mdc_antirrebote.sv
// 2-flop synchroniser plus debounce counter; flags the cycle the accepted level rises.
module mdc_antirrebote
    import mdc_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic rise
);

    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // rise is combinational so the caller latches on the same edge the level is accepted
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        rise  = 1'b0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                lvl_d = s2_q;
                rise  = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= btn_raw;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mdc_entradas.sv
// Coin pulse classifier, selection latches and partial-transaction timeout
// feeding the coffee-machine FSM.
module mdc_entradas
    import mdc_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int C5_MIN     = C5_MIN_DEF,
    parameter int C5_MAX     = C5_MAX_DEF,
    parameter int C10_MIN    = C10_MIN_DEF,
    parameter int C10_MAX    = C10_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic coin_sns,
    input  logic btn_cafe,
    input  logic btn_te,
    input  logic clr,
    output logic hm,
    output logic mc,
    output logic md,
    output logic bp,
    output logic bc,
    output logic bt,
    output logic rej
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic             cs1_q, cs2_q;
    coin_st_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hm_q, hm_d, mc_q, mc_d, md_q, md_d;
    logic             bp_q, bp_d, bc_q, bc_d, bt_q, bt_d;
    logic             rej_q, rej_d;
    logic [TW-1:0]    to_q, to_d;
    logic             rise_c, rise_t;
    logic             classify, is5, is10, one_side, tmo, flush;

    mdc_antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cafe (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_cafe),
        .rise    (rise_c)
    );

    mdc_antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_te (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_te),
        .rise    (rise_t)
    );

    // MEAS is only left on a low sample, so a high level in IDLE is a fresh rise
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (cs2_q) begin
                state_d = MEAS;
                cnt_d   = CNT_W'(1);
            end
            MEAS: if (cs2_q) begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else begin
                state_d = CLAS;
            end
            CLAS:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign classify = (state_q == CLAS);
    assign is5      = in_range(cnt_q, C5_MIN, C5_MAX);
    assign is10     = in_range(cnt_q, C10_MIN, C10_MAX);
    assign one_side = hm_q ^ bp_q;
    assign tmo      = one_side && (to_q == TW'(TIMEOUT - 1));
    assign flush    = clr | tmo;

    always_comb begin
        hm_d  = hm_q;
        mc_d  = mc_q;
        md_d  = md_q;
        bp_d  = bp_q;
        bc_d  = bc_q;
        bt_d  = bt_q;
        rej_d = 1'b0;
        to_d  = one_side ? to_q + 1'b1 : '0;
        if (flush) begin
            // any coin being classified now is handed back, valid or not
            hm_d  = 1'b0;
            mc_d  = 1'b0;
            md_d  = 1'b0;
            bp_d  = 1'b0;
            bc_d  = 1'b0;
            bt_d  = 1'b0;
            to_d  = '0;
            rej_d = classify | (tmo & hm_q);
        end else begin
            if (classify) begin
                if ((is5 || is10) && !hm_q) begin
                    hm_d = 1'b1;
                    mc_d = is5;
                    md_d = ~is5;
                end else begin
                    rej_d = 1'b1;
                end
            end
            if (!bp_q && (rise_c ^ rise_t)) begin
                bp_d = 1'b1;
                bc_d = rise_c;
                bt_d = rise_t;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs1_q   <= 1'b0;
            cs2_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            hm_q    <= 1'b0;
            mc_q    <= 1'b0;
            md_q    <= 1'b0;
            bp_q    <= 1'b0;
            bc_q    <= 1'b0;
            bt_q    <= 1'b0;
            rej_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            cs1_q   <= coin_sns;
            cs2_q   <= cs1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hm_q    <= hm_d;
            mc_q    <= mc_d;
            md_q    <= md_d;
            bp_q    <= bp_d;
            bc_q    <= bc_d;
            bt_q    <= bt_d;
            rej_q   <= rej_d;
            to_q    <= to_d;
        end
    end

    assign hm  = hm_q;
    assign mc  = mc_q;
    assign md  = md_q;
    assign bp  = bp_q;
    assign bc  = bc_q;
    assign bt  = bt_q;
    assign rej = rej_q;

endmodule

// File: tb/tb_mdc_entradas.sv
// Scoreboard bench: stimulus queues every expected output change with its cycle,
// a monitor pops and compares whenever the output vector changes.
module tb_mdc_entradas;

    logic clk = 1'b0, rst = 1'b0;
    logic coin_sns = 1'b0, btn_cafe = 1'b0, btn_te = 1'b0, clr = 1'b0;
    logic hm, mc, md, bp, bc, bt, rej;
    logic [6:0] ov;
    int cyc = 0, n_vec = 0, n_err = 0;

    typedef struct {
        int         cyc;
        logic [6:0] v;
    } exp_t;
    exp_t sb[$];

    mdc_entradas dut (
        .clk(clk), .rst(rst), .coin_sns(coin_sns), .btn_cafe(btn_cafe),
        .btn_te(btn_te), .clr(clr), .hm(hm), .mc(mc), .md(md), .bp(bp),
        .bc(bc), .bt(bt), .rej(rej)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {rej, hm, mc, md, bp, bc, bt}
    assign ov = {rej, hm, mc, md, bp, bc, bt};

    task automatic expect_at(input int c, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coin(input int n, output int c0);
        @(negedge clk);
        coin_sns = 1'b1;
        repeat (n) @(negedge clk);
        coin_sns = 1'b0;
        c0 = cyc;
    endtask

    task automatic pulse_clr(output int c);
        @(negedge clk);
        clr = 1'b1;
        c = cyc;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic press(input logic cafe, input logic te, output int s);
        @(negedge clk);
        btn_cafe = cafe;
        btn_te   = te;
        s = cyc;
    endtask

    initial begin : monitor
        logic [6:0] prev;
        exp_t e;
        prev = '0;
        wait (rst === 1'b1);
        forever begin
            @(negedge clk);
            if (ov !== prev) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change cyc=%0d got=%b want=no change", cyc, ov);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.v !== ov)
                    begin
                        n_err++;
                        $display("FAIL out_vec cyc=%0d got=%b want=%b at cyc %0d", cyc, ov, e.v, e.cyc);
                    end
                end
                prev = ov;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int c, s, h;
        // reset held with random activity on the inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            coin_sns = 1'($urandom_range(0, 1));
            btn_cafe = 1'($urandom_range(0, 1));
            btn_te   = 1'($urandom_range(0, 1));
            clr      = 1'($urandom_range(0, 1));
            if (i >= 2) begin
                n_vec++;
                if (ov !== 7'b0) begin
                    n_err++;
                    $display("FAIL reset_outputs cyc=%0d got=%b want=0000000", cyc, ov);
                end
            end
        end
        @(negedge clk);
        coin_sns = 1'b0; btn_cafe = 1'b0; btn_te = 1'b0; clr = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(10);
        n_vec++;
        if (ov !== 7'b0) begin
            n_err++;
            $display("FAIL post_reset_idle cyc=%0d got=%b want=0000000", cyc, ov);
        end

        // valid 5 coin, then a valid 10 is bounced because one coin is held
        coin(5, c);  expect_at(c + 4, 7'b0110000);
        idle(8);
        coin(12, c); expect_at(c + 4, 7'b1110000); expect_at(c + 5, 7'b0110000);
        idle(8);
        pulse_clr(c); expect_at(c + 1, 7'b0000000);
        idle(3);

        // out-of-band and saturating pulses
        coin(8, c);   expect_at(c + 4, 7'b1000000); expect_at(c + 5, 7'b0000000);
        idle(8);
        coin(300, c); expect_at(c + 4, 7'b1000000); expect_at(c + 5, 7'b0000000);
        idle(8);

        // bouncing café press accepted once
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); btn_cafe = 1'b1;
            idle(2);        btn_cafe = 1'b0;
            idle(1);
        end
        press(1'b1, 1'b0, s); expect_at(s + 6, 7'b0000110);
        idle(10); btn_cafe = 1'b0;
        idle(8);
        press(1'b0, 1'b1, s);
        idle(10); btn_te = 1'b0;
        idle(8);
        pulse_clr(c); expect_at(c + 1, 7'b0000000);
        idle(3);

        // simultaneous press latches nothing
        press(1'b1, 1'b1, s);
        idle(12); btn_cafe = 1'b0; btn_te = 1'b0;
        idle(10);

        // full transaction then acknowledge, then a fresh coin
        coin(12, c); expect_at(c + 4, 7'b0101000);
        idle(6);
        press(1'b0, 1'b1, s); expect_at(s + 6, 7'b0101101);
        idle(10); btn_te = 1'b0;
        idle(8);
        pulse_clr(c); expect_at(c + 1, 7'b0000000);
        idle(3);
        coin(5, c); expect_at(c + 4, 7'b0110000);
        idle(6);
        pulse_clr(c); expect_at(c + 1, 7'b0000000);
        idle(3);

        // clr on the classification edge discards the valid coin with a reject
        coin(5, c);
        idle(3);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        expect_at(c + 4, 7'b1000000); expect_at(c + 5, 7'b0000000);
        idle(8);

        // coin alone times out with a reject
        coin(5, c);
        h = c + 4;
        expect_at(h, 7'b0110000);
        expect_at(h + 255, 7'b1000000);
        expect_at(h + 256, 7'b0000000);
        idle(270);

        // selection alone times out silently
        press(1'b1, 1'b0, s);
        h = s + 6;
        expect_at(h, 7'b0000110);
        expect_at(h + 255, 7'b0000000);
        idle(10); btn_cafe = 1'b0;
        idle(260);

        idle(5);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL pending_events cyc=%0d got=%0d left want=0 (next at cyc %0d)", cyc, sb.size(), sb[0].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
